// File: rtl/mulalu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mulalu_pkg;

    localparam int unsigned W_FUNC = 5;
    localparam int unsigned W_DATA = 32;
    localparam int unsigned W_CNT  = 6;

    localparam logic [W_FUNC-1:0] FUNC_NOP = 5'b00000;
    localparam logic [W_FUNC-1:0] FUNC_MUL = 5'b11000;
    localparam logic [W_FUNC-1:0] FUNC_DIV = 5'b11010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Absolute value of a two's-complement operand when signed, else pass-through.
    function automatic logic [W_DATA-1:0] magnitude(input logic [W_DATA-1:0] x,
                                                    input logic             is_signed);
        return (is_signed && x[W_DATA-1]) ? W_DATA'(~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mulalu_div.sv
// Radix-2 restoring divider on magnitudes with sign fix-up and divide-by-zero result.
module mulalu_div
    import mulalu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [W_DATA-1:0] dividend,
    input  logic [W_DATA-1:0] divisor,
    input  logic              is_signed,
    output logic [W_DATA-1:0] quotient,
    output logic [W_DATA-1:0] remainder
);

    logic [W_DATA-1:0] rem_q, rem_d;
    logic [W_DATA-1:0] quo_q, quo_d;
    logic [W_DATA-1:0] dvsr_q, dvsr_d;
    logic [W_DATA-1:0] a_q, a_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;

    logic [W_DATA:0]   shifted;
    logic [W_DATA:0]   diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            a_q    <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
            a_q    <= a_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
        end
    end

    // The dividend sits in quo_q and shifts out MSB-first as quotient bits shift in.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        a_d     = a_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        shifted = {rem_q, quo_q[W_DATA-1]};
        diff    = shifted - {1'b0, dvsr_q};
        if (load) begin
            rem_d  = '0;
            quo_d  = magnitude(dividend, is_signed);
            dvsr_d = magnitude(divisor, is_signed);
            a_d    = dividend;
            qneg_d = is_signed && (dividend[W_DATA-1] ^ divisor[W_DATA-1]);
            rneg_d = is_signed && dividend[W_DATA-1];
            dz_d   = (divisor == '0);
        end else if (step) begin
            if (!diff[W_DATA]) begin
                rem_d = diff[W_DATA-1:0];
                quo_d = {quo_q[W_DATA-2:0], 1'b1};
            end else begin
                rem_d = shifted[W_DATA-1:0];
                quo_d = {quo_q[W_DATA-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        if (dz_q) begin
            quotient  = '1;
            remainder = a_q;
        end else begin
            quotient  = qneg_q ? W_DATA'(~quo_q + 1'b1) : quo_q;
            remainder = rneg_q ? W_DATA'(~rem_q + 1'b1) : rem_q;
        end
    end

endmodule

// File: rtl/mulalu.sv
// Iterative 32-bit multiply/divide unit writing HI/LO, 33-cycle latency per operation.
module mulalu
    import mulalu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_FUNC-1:0] func,
    input  logic              sign,
    input  logic [W_DATA-1:0] source_a,
    input  logic [W_DATA-1:0] source_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [W_DATA-1:0] hi_result,
    output logic [W_DATA-1:0] lo_result
);

    state_e              state_q, state_d;
    logic [W_CNT-1:0]    cnt_q, cnt_d;
    logic [2*W_DATA-1:0] prod_q, prod_d;
    logic [W_DATA-1:0]   mcand_q, mcand_d;
    logic                mneg_q, mneg_d;
    logic                is_div_q, is_div_d;
    logic [W_DATA-1:0]   hi_q, hi_d;
    logic [W_DATA-1:0]   lo_q, lo_d;

    logic                start_c;
    logic [W_DATA:0]     sum_c;
    logic [2*W_DATA-1:0] prod_fix_c;
    logic [W_DATA-1:0]   div_quo_c;
    logic [W_DATA-1:0]   div_rem_c;
    logic [W_DATA-1:0]   res_hi_c;
    logic [W_DATA-1:0]   res_lo_c;

    assign start_c = (state_q == IDLE) && !flush &&
                     ((func == FUNC_MUL) || (func == FUNC_DIV));

    mulalu_div u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start_c && (func == FUNC_DIV)),
        .step      ((state_q == DIV) && !flush),
        .dividend  (source_a),
        .divisor   (source_b),
        .is_signed (sign),
        .quotient  (div_quo_c),
        .remainder (div_rem_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mneg_q   <= mneg_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        prod_fix_c = mneg_q ? (2*W_DATA)'(~prod_q + 1'b1) : prod_q;
        if (is_div_q) begin
            res_hi_c = div_rem_c;
            res_lo_c = div_quo_c;
        end else begin
            res_hi_c = prod_fix_c[2*W_DATA-1:W_DATA];
            res_lo_c = prod_fix_c[W_DATA-1:0];
        end
    end

    // Next-state and datapath; the product register holds {partial, multiplier}.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mneg_d   = mneg_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sum_c    = {1'b0, prod_q[2*W_DATA-1:W_DATA]} +
                   {1'b0, (prod_q[0] ? mcand_q : {W_DATA{1'b0}})};
        unique case (state_q)
            IDLE: begin
                if (start_c) begin
                    cnt_d    = '0;
                    is_div_d = (func == FUNC_DIV);
                    state_d  = (func == FUNC_DIV) ? DIV : MUL;
                    if (func == FUNC_MUL) begin
                        prod_d  = {{W_DATA{1'b0}}, magnitude(source_a, sign)};
                        mcand_d = magnitude(source_b, sign);
                        mneg_d  = sign && (source_a[W_DATA-1] ^ source_b[W_DATA-1]);
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    prod_d = {sum_c, prod_q[W_DATA-1:1]};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == W_CNT'(W_DATA - 1)) state_d = DONE;
                end
            end
            DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == W_CNT'(W_DATA - 1)) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d = res_hi_c;
                    lo_d = res_lo_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fresh results are presented in the done cycle itself and latched at its end.
    assign done      = (state_q == DONE) && !flush;
    assign busy      = rst_n && (start_c || (state_q == MUL) || (state_q == DIV));
    assign hi_result = done ? res_hi_c : hi_q;
    assign lo_result = done ? res_lo_c : lo_q;

endmodule

// File: tb/tb_mulalu.sv
// Directed vector bench for mulalu: result table plus flush/reset/back-to-back sequences.
module tb_mulalu;
    import mulalu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  func;
    logic        sign;
    logic [31:0] source_a;
    logic [31:0] source_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi_result;
    logic [31:0] lo_result;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] prev_hi = 32'h0;
    logic [31:0] prev_lo = 32'h0;

    typedef struct {
        logic [4:0]  f;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    mulalu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .func      (func),
        .sign      (sign),
        .source_a  (source_a),
        .source_b  (source_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi_result (hi_result),
        .lo_result (lo_result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start an op in cycle 0 and check busy, held outputs, done in cycle 33 and the result.
    task automatic run_op(input logic [4:0] f, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int busy_err;
        int held_err;
        busy_err = 0;
        held_err = 0;
        @(negedge clk);
        func = f; sign = s; source_a = a; source_b = b; #1;
        check("busy_start", 64'(busy), 64'(1));
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            func = FUNC_NOP; #1;
            if (busy !== 1'b1 || done !== 1'b0) busy_err++;
            if (hi_result !== prev_hi || lo_result !== prev_lo) held_err++;
        end
        check("busy_iter_errs", 64'(busy_err), 64'(0));
        check("held_iter_errs", 64'(held_err), 64'(0));
        @(negedge clk); #1;
        check("done_c33", 64'(done), 64'(1));
        check("busy_c33", 64'(busy), 64'(0));
        check("hi", 64'(hi_result), 64'(eh));
        check("lo", 64'(lo_result), 64'(el));
        @(negedge clk); #1;
        check("done_c34", 64'(done), 64'(0));
        check("hilo_hold", {hi_result, lo_result}, {eh, el});
        prev_hi = eh;
        prev_lo = el;
    endtask

    initial begin
        int errs;
        vecs[0]  = '{FUNC_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{FUNC_MUL, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{FUNC_DIV, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{FUNC_DIV, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{FUNC_DIV, 1'b0, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[5]  = '{FUNC_DIV, 1'b1, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[6]  = '{FUNC_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7]  = '{FUNC_MUL, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{FUNC_DIV, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{FUNC_MUL, 1'b0, 32'd2,        32'd3,        32'd0,        32'd6};
        vecs[10] = '{FUNC_DIV, 1'b1, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[11] = '{FUNC_MUL, 1'b1, 32'h00003039, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7};

        rst_n = 1'b0; func = FUNC_NOP; sign = 1'b0; source_a = '0; source_b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hilo", {hi_result, lo_result}, 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].f, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);

        // Flush in iteration cycle 10: busy drops, no done, results untouched.
        @(negedge clk);
        func = FUNC_MUL; sign = 1'b0; source_a = 32'd5; source_b = 32'd5;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            func = FUNC_NOP;
        end
        @(negedge clk);
        flush = 1'b1; #1;
        check("flush_done", 64'(done), 64'(0));
        errs = 0;
        for (int c = 11; c <= 40; c++) begin
            @(negedge clk);
            flush = 1'b0; #1;
            if (busy !== 1'b0 || done !== 1'b0) errs++;
            if (hi_result !== prev_hi || lo_result !== prev_lo) errs++;
        end
        check("flush_mul_errs", 64'(errs), 64'(0));

        // Flush coinciding with a start request suppresses it.
        @(negedge clk);
        func = FUNC_DIV; source_a = 32'd9; source_b = 32'd3; flush = 1'b1; #1;
        check("flush_start_busy", 64'(busy), 64'(0));
        errs = 0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            func = FUNC_NOP; flush = 1'b0; #1;
            if (busy !== 1'b0 || done !== 1'b0) errs++;
        end
        check("flush_start_errs", 64'(errs), 64'(0));

        // Flush in the DONE cycle: no strobe and HI/LO keep the previous op's values.
        @(negedge clk);
        func = FUNC_MUL; sign = 1'b0; source_a = 32'd4; source_b = 32'd4;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            func = FUNC_NOP;
        end
        @(negedge clk);
        flush = 1'b1; #1;
        check("flush_done_strobe", 64'(done), 64'(0));
        check("flush_done_hilo", {hi_result, lo_result}, {prev_hi, prev_lo});
        @(negedge clk);
        flush = 1'b0; #1;
        check("flush_done_after", {hi_result, lo_result}, {prev_hi, prev_lo});

        // Back-to-back: func held through DONE is ignored, accepted in the following IDLE.
        @(negedge clk);
        func = FUNC_MUL; sign = 1'b0; source_a = 32'd10; source_b = 32'd10;
        for (int c = 1; c <= 32; c++) @(negedge clk);
        @(negedge clk); #1;
        check("b2b_done", 64'(done), 64'(1));
        check("b2b_busy_done", 64'(busy), 64'(0));
        check("b2b_lo", 64'(lo_result), 64'(100));
        @(negedge clk); #1;
        check("b2b_idle_start", 64'(busy), 64'(1));
        @(negedge clk);
        func = FUNC_NOP; #1;
        check("b2b_running", 64'(busy), 64'(1));
        prev_hi = 32'd0;
        prev_lo = 32'd100;

        // Reset in cycle 5 of a multiply aborts it, then a fresh 2*3.
        @(negedge clk);
        rst_n = 1'b0; #1;
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        check("rst_mid_hilo", {hi_result, lo_result}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        @(negedge clk);
        func = FUNC_MUL; source_a = 32'd7; source_b = 32'd7;
        repeat (5) begin
            @(negedge clk);
            func = FUNC_NOP;
        end
        rst_n = 1'b0; #1;
        check("rst_c5_busy", 64'(busy), 64'(0));
        check("rst_c5_hilo", {hi_result, lo_result}, 64'(0));
        errs = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) errs++;
        end
        check("rst_hold_errs", 64'(errs), 64'(0));
        rst_n = 1'b1;
        run_op(FUNC_MUL, 1'b0, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
